ls_ahb_master: RTL

- AHB-Lite master for the load/store (LS) stage: converts one LS memory request into a single AHB-Lite transfer.
- Sits between the LS stage and the data bus. It is the requester side of the pipeline stall/flush interface: it raises the LS stall request toward the pipeline controller and consumes the controller's LS flush bit.
- Returns read data and bus-error status to LS/WB and the exception unit.

---
 rtl/ls_ahb_master_pkg.sv | 33 +++
 rtl/ls_ahb_wdata_align.sv | 21 ++
 rtl/ls_ahb_master.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ls_ahb_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the LS-stage bus master.
// misaligned() backs the optional LS_AHB_MISALIGN_CHK_EN alignment check.
package ls_ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } ls_state_e;

  function automatic logic misaligned(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (hsize)
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ls_ahb_wdata_align.sv
// Replicates right-aligned store data across all byte lanes according to size,
// so the slave can pick its lane from haddr without the master shifting data.
module ls_ahb_wdata_align
  import ls_ahb_master_pkg::*;
(
  input  logic [2:0]  hsize,
  input  logic [31:0] wdata,
  output logic [31:0] lanes
);

  // Lane replication: byte x4, half x2, word unchanged.
  always_comb begin
    lanes = wdata;
    case (hsize)
      HSIZE_BYTE: lanes = {4{wdata[7:0]}};
      HSIZE_HALF: lanes = {2{wdata[15:0]}};
      default:    lanes = wdata;
    endcase
  end

endmodule

// File: rtl/ls_ahb_master.sv
// AHB-Lite master turning one LS load/store into a single SINGLE transfer.
// Optional macro LS_AHB_MISALIGN_CHK_EN rejects misaligned half/word accesses.
module ls_ahb_master
  import ls_ahb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [1:0]            ls_size_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  input  logic                  ls_flush_i,
  output logic                  ls_stallreq_o,
  output logic                  ls_done_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
`ifdef LS_AHB_MISALIGN_CHK_EN
  output logic                  ls_misalign_o,
`endif
  output logic                  ls_buserr_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic                  hresp_i
);

  ls_state_e             state;
  ls_state_e             state_nx;
  logic                  start;
  logic                  bad_align;
  logic                  drop;
  logic                  err_r;
  logic                  we_r;
  logic [1:0]            size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_r;

`ifdef LS_AHB_MISALIGN_CHK_EN
  logic misalign_r;
  assign bad_align = misaligned({1'b0, ls_size_i}, ls_addr_i[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a rejected misaligned access skips the bus entirely.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ls_req_i && !ls_flush_i) begin
          start    = 1'b1;
          state_nx = bad_align ? ST_DONE : ST_ADDR;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ADDR: state_nx = hready_i ? ST_DATA : ST_ADDR;
      ST_DATA: state_nx = hready_i ? ST_DONE : ST_DATA;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture, response capture and flush bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      wdata_r <= {DATA_WIDTH{1'b0}};
      rdata_r <= {DATA_WIDTH{1'b0}};
      err_r   <= 1'b0;
      drop    <= 1'b0;
`ifdef LS_AHB_MISALIGN_CHK_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      if (start) begin
        addr_r  <= ls_addr_i;
        we_r    <= ls_we_i;
        size_r  <= ls_size_i;
        wdata_r <= ls_wdata_i;
        err_r   <= bad_align;
`ifdef LS_AHB_MISALIGN_CHK_EN
        misalign_r <= bad_align;
`endif
      end else if (state == ST_DATA && hready_i) begin
        if (hresp_i) err_r   <= 1'b1;
        else         rdata_r <= hrdata_i;
      end
      // A started transfer always finishes on the bus; flush only hides its result.
      if (state == ST_DONE) begin
        drop <= 1'b0;
      end else if ((state == ST_ADDR || state == ST_DATA) && ls_flush_i) begin
        drop <= 1'b1;
      end
    end
  end

  ls_ahb_wdata_align u_wdata_align (
    .hsize (hsize_o),
    .wdata (wdata_r),
    .lanes (hwdata_o)
  );

  assign ls_stallreq_o = drop | (ls_req_i & (state != ST_DONE));
  assign ls_done_o     = (state == ST_DONE) & ~drop;
  assign ls_buserr_o   = ls_done_o & err_r;
  assign ls_rdata_o    = rdata_r;
`ifdef LS_AHB_MISALIGN_CHK_EN
  assign ls_misalign_o = ls_done_o & misalign_r;
`endif
  assign haddr_o  = addr_r;
  assign htrans_o = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite_o = we_r;
  assign hsize_o  = {1'b0, size_r};
  assign hburst_o = HBURST_SINGLE;
  assign hprot_o  = HPROT_DATA;

endmodule
